// File: rtl/drive_pkg.sv
// Shared types and constants for the drive PWM scheduler: direction codes,
// scheduler FSM states and the packed command word seen by the modulator.
package drive_pkg;

    localparam int SLOTS = 24;

    localparam logic [1:0] DIR_FWD = 2'd0;
    localparam logic [1:0] DIR_NEU = 2'd1;
    localparam logic [1:0] DIR_REV = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DWELL
    } fsm_e;

    typedef struct packed {
        logic [2:0] speed;
        logic [1:0] dir;
    } mod_t;

    localparam mod_t MOD_NEUTRAL = '{speed: 3'd0, dir: DIR_NEU};

    // A reversal is a hard swap between forward and reverse; neutral never counts.
    function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] nxt);
        return ((cur == DIR_FWD) && (nxt == DIR_REV)) ||
               ((cur == DIR_REV) && (nxt == DIR_FWD));
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Servo frame timebase: free-running frame counter, update/capture strobes,
// captured pulse width and the registered PWM compare.
module servo_frame_timer #(
    parameter int          FRAME_TICKS = 2000000,
    parameter logic [20:0] RESET_PULSE = 21'd150000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [20:0] pulse_i,
    output logic        frame_start_o,
    output logic        upd_pt_o,
    output logic        cap_pt_o,
    output logic        pwm_o
);

    logic [20:0] frame_cnt_q, frame_cnt_d;
    logic [20:0] pulse_width_q;
    logic        pwm_q;
    logic        frame_start_q;

    // Update point sits three cycles ahead of capture so a registered modulator
    // has settled on the new slot before its pulse width is sampled.
    assign upd_pt_o = (frame_cnt_q == 21'(FRAME_TICKS - 4));
    assign cap_pt_o = (frame_cnt_q == 21'(FRAME_TICKS - 1));

    assign frame_cnt_d   = cap_pt_o ? 21'd0 : frame_cnt_q + 21'd1;
    assign frame_start_o = frame_start_q;
    assign pwm_o         = pwm_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q   <= 21'd0;
            pulse_width_q <= RESET_PULSE;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            pwm_q         <= (frame_cnt_q < pulse_width_q);
            frame_start_q <= cap_pt_o;
            if (cap_pt_o) begin
                pulse_width_q <= pulse_i;
            end
        end
    end

endmodule

// File: rtl/drive_pulse_scheduler.sv
// Per-channel drive scheduler: command handshake, pending register, reversal
// dwell FSM and slot counter, all advanced once per servo frame.
module drive_pulse_scheduler #(
    parameter int CLK_RATE       = 100000000,
    parameter int FRAME_HZ       = 50,
    parameter int SLOTS          = drive_pkg::SLOTS,
    parameter int NEUTRAL_FRAMES = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_mod,
    input  logic        stop,
    output logic [4:0]  State,
    output logic [4:0]  ModInfo,
    input  logic [20:0] Pulse,
    output logic        pwm_out,
    output logic        frame_start,
    output logic        busy
);

    import drive_pkg::*;

    localparam int          FRAME_TICKS = CLK_RATE / FRAME_HZ;
    localparam logic [20:0] RESET_PULSE = 21'(CLK_RATE * 3 / 2000);
    localparam int          DWELL_W     = (NEUTRAL_FRAMES > 1) ? $clog2(NEUTRAL_FRAMES) : 1;

    fsm_e               state_q, state_d;
    mod_t               mod_q, mod_d;
    mod_t               pend_q;
    mod_t               cmd_in;
    logic               pend_v_q, pend_v_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [4:0]         slot_q, slot_d;
    logic               upd_pt;
    logic               cap_pt;
    logic               fire;
    logic               consume;

    servo_frame_timer #(
        .FRAME_TICKS (FRAME_TICKS),
        .RESET_PULSE (RESET_PULSE)
    ) u_timer (
        .clk_i         (CLK),
        .rst_ni        (RST_N),
        .pulse_i       (Pulse),
        .frame_start_o (frame_start),
        .upd_pt_o      (upd_pt),
        .cap_pt_o      (cap_pt),
        .pwm_o         (pwm_out)
    );

    // Illegal direction 3 is folded to neutral at acceptance time.
    assign cmd_in.speed = cmd_mod[4:2];
    assign cmd_in.dir   = (cmd_mod[1:0] == 2'd3) ? DIR_NEU : cmd_mod[1:0];

    assign cmd_ready = !pend_v_q && !stop;
    assign fire      = cmd_valid && cmd_ready;
    assign pend_v_d  = consume ? 1'b0 : (fire ? 1'b1 : pend_v_q);

    assign slot_d = (slot_q == 5'(SLOTS - 1)) ? 5'd0 : slot_q + 5'd1;

    assign State   = slot_q;
    assign ModInfo = mod_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (upd_pt) begin
            if (stop) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pend_v_q && (pend_q.dir != DIR_NEU)) begin
                            state_d = RUN;
                        end
                    end
                    RUN: begin
                        if (pend_v_q) begin
                            if (pend_q.dir == DIR_NEU) begin
                                state_d = IDLE;
                            end else if (is_reversal(mod_q.dir, pend_q.dir)) begin
                                state_d = DWELL;
                            end
                        end
                    end
                    DWELL: begin
                        if (dwell_q == '0) begin
                            state_d = RUN;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // During a dwell the pending reversal stays parked, which also keeps cmd_ready low.
    always_comb begin
        mod_d   = mod_q;
        dwell_d = dwell_q;
        consume = 1'b0;
        busy    = (state_q == DWELL);
        if (upd_pt) begin
            if (stop) begin
                mod_d   = MOD_NEUTRAL;
                consume = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pend_v_q) begin
                            consume = 1'b1;
                            if (pend_q.dir != DIR_NEU) begin
                                mod_d = pend_q;
                            end
                        end
                    end
                    RUN: begin
                        if (pend_v_q) begin
                            if (pend_q.dir == DIR_NEU) begin
                                mod_d   = MOD_NEUTRAL;
                                consume = 1'b1;
                            end else if (is_reversal(mod_q.dir, pend_q.dir)) begin
                                mod_d   = MOD_NEUTRAL;
                                dwell_d = DWELL_W'(NEUTRAL_FRAMES - 1);
                            end else begin
                                mod_d   = pend_q;
                                consume = 1'b1;
                            end
                        end
                    end
                    DWELL: begin
                        if (dwell_q != '0) begin
                            dwell_d = dwell_q - DWELL_W'(1);
                        end else begin
                            mod_d   = pend_q;
                            consume = 1'b1;
                        end
                    end
                    default: begin
                        mod_d   = MOD_NEUTRAL;
                        consume = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mod_q    <= MOD_NEUTRAL;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            dwell_q  <= '0;
            slot_q   <= 5'd0;
        end else begin
            mod_q    <= mod_d;
            dwell_q  <= dwell_d;
            pend_v_q <= pend_v_d;
            if (fire) begin
                pend_q <= cmd_in;
            end
            if (upd_pt) begin
                slot_q <= slot_d;
            end
        end
    end

endmodule

// File: tb/tb_drive_pulse_scheduler.sv
// Directed bench for drive_pulse_scheduler on a shortened 80-clock frame
// (CLK_RATE 4000, FRAME_HZ 50), reset pulse width 4000*3/2000 = 6 clocks.
module tb_drive_pulse_scheduler;

    localparam int FT = 80;

    logic        CLK;
    logic        RST_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_mod;
    logic        stop;
    logic [4:0]  State;
    logic [4:0]  ModInfo;
    logic [20:0] Pulse;
    logic        pwm_out;
    logic        frame_start;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;
    int expState = 0;
    int hi       = 0;

    drive_pulse_scheduler #(
        .CLK_RATE       (4000),
        .FRAME_HZ       (50),
        .SLOTS          (24),
        .NEUTRAL_FRAMES (5)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mod     (cmd_mod),
        .stop        (stop),
        .State       (State),
        .ModInfo     (ModInfo),
        .Pulse       (Pulse),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .busy        (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] mod);
        cmd_valid = valid;
        cmd_mod   = mod;
    endtask

    // pos mirrors the frame counter; the update point is the edge leaving pos FT-4.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (pos == FT - 4) expState = (expState == 23) ? 0 : expState + 1;
        pos = (pos + 1) % FT;
    endtask

    task automatic waitPos(input int p);
        while (pos != p) tick();
    endtask

    task automatic measureFrame(output int high);
        waitPos(0);
        high = 0;
        repeat (FT) begin
            tick();
            high += int'(pwm_out);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        stop  = 1'b0;
        Pulse = 21'd6;
        applyStimulus(1'b0, 5'd0);
        #12;
        checkOutput("rst_State",       32'(State),       32'd0);
        checkOutput("rst_ModInfo",     32'(ModInfo),     32'd1);
        checkOutput("rst_pwm",         32'(pwm_out),     32'd0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        checkOutput("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        @(posedge CLK);
        #1;
        RST_N    = 1'b1;
        pos      = 0;
        expState = 0;

        $display("[TB] idle frame");
        measureFrame(hi);
        checkOutput("idle_high_time", 32'(hi),          32'd6);
        checkOutput("frame_start",    32'(frame_start), 32'd1);
        checkOutput("idle_State",     32'(State),       32'(expState));
        checkOutput("idle_ModInfo",   32'(ModInfo),     32'd1);
        tick();
        checkOutput("frame_start_one", 32'(frame_start), 32'd0);

        $display("[TB] forward command");
        Pulse = 21'd4;
        waitPos(20);
        applyStimulus(1'b1, 5'b11100);
        checkOutput("fwd_ready_before", 32'(cmd_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0);
        checkOutput("fwd_ready_pend", 32'(cmd_ready), 32'd0);
        waitPos(76);
        checkOutput("fwd_mod_pre_upd", 32'(ModInfo), 32'd1);
        tick();
        checkOutput("fwd_mod_applied", 32'(ModInfo),   32'b11100);
        checkOutput("fwd_ready_after", 32'(cmd_ready), 32'd1);
        checkOutput("fwd_State",       32'(State),     32'(expState));
        measureFrame(hi);
        checkOutput("fwd_high_time", 32'(hi), 32'd4);

        $display("[TB] reversal");
        waitPos(30);
        applyStimulus(1'b1, 5'b10010);
        tick();
        applyStimulus(1'b0, 5'd0);
        checkOutput("rev_ready_pend", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            waitPos(76);
            tick();
            checkOutput("rev_dwell_mod",  32'(ModInfo), 32'd1);
            checkOutput("rev_dwell_busy", 32'(busy),    32'd1);
            if (i == 2) checkOutput("rev_dwell_ready", 32'(cmd_ready), 32'd0);
        end
        waitPos(76);
        tick();
        checkOutput("rev_mod_applied", 32'(ModInfo),   32'b10010);
        checkOutput("rev_busy_clear",  32'(busy),      32'd0);
        checkOutput("rev_ready_after", 32'(cmd_ready), 32'd1);

        $display("[TB] stop during dwell");
        waitPos(10);
        applyStimulus(1'b1, 5'b01000);
        tick();
        applyStimulus(1'b0, 5'd0);
        waitPos(76);
        tick();
        checkOutput("stop_enter_dwell", 32'(busy), 32'd1);
        waitPos(20);
        stop = 1'b1;
        #1;
        checkOutput("stop_ready_low", 32'(cmd_ready), 32'd0);
        waitPos(76);
        tick();
        checkOutput("stop_mod",        32'(ModInfo),   32'd1);
        checkOutput("stop_busy",       32'(busy),      32'd0);
        checkOutput("stop_ready_held", 32'(cmd_ready), 32'd0);
        waitPos(20);
        stop = 1'b0;
        #1;
        checkOutput("stop_ready_release", 32'(cmd_ready), 32'd1);
        waitPos(76);
        tick();
        checkOutput("stop_rev_dropped", 32'(ModInfo), 32'd1);

        $display("[TB] back-to-back and illegal direction");
        waitPos(10);
        applyStimulus(1'b1, 5'b01100);
        tick();
        applyStimulus(1'b1, 5'b10111);
        checkOutput("b2b_stalled", 32'(cmd_ready), 32'd0);
        waitPos(76);
        checkOutput("b2b_mod_pre", 32'(ModInfo), 32'd1);
        tick();
        checkOutput("b2b_mod_first", 32'(ModInfo),   32'b01100);
        checkOutput("b2b_ready_gap", 32'(cmd_ready), 32'd1);
        tick();
        checkOutput("b2b_second_taken", 32'(cmd_ready), 32'd0);
        applyStimulus(1'b0, 5'd0);
        waitPos(76);
        checkOutput("b2b_mod_stable", 32'(ModInfo), 32'b01100);
        tick();
        checkOutput("illegal_dir_neutral", 32'(ModInfo),   32'd1);
        checkOutput("illegal_ready",       32'(cmd_ready), 32'd1);

        $display("[TB] handshake on update point");
        waitPos(76);
        applyStimulus(1'b1, 5'b00100);
        tick();
        applyStimulus(1'b0, 5'd0);
        checkOutput("simul_mod_unchanged", 32'(ModInfo),   32'd1);
        checkOutput("simul_ready",         32'(cmd_ready), 32'd0);
        waitPos(76);
        tick();
        checkOutput("simul_mod_next", 32'(ModInfo), 32'b00100);

        $display("[TB] slot wrap");
        checkOutput("wrap_State_track", 32'(State), 32'(expState));
        while (expState != 23) begin
            waitPos(76);
            tick();
        end
        checkOutput("wrap_State_23", 32'(State), 32'd23);
        waitPos(76);
        tick();
        checkOutput("wrap_State_0", 32'(State), 32'd0);

        $display("[TB] reset mid-pulse");
        Pulse = 21'd6;
        waitPos(0);
        waitPos(2);
        checkOutput("midrst_pwm_high", 32'(pwm_out), 32'd1);
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_pwm",         32'(pwm_out),     32'd0);
        checkOutput("midrst_ModInfo",     32'(ModInfo),     32'd1);
        checkOutput("midrst_State",       32'(State),       32'd0);
        checkOutput("midrst_busy",        32'(busy),        32'd0);
        checkOutput("midrst_frame_start", 32'(frame_start), 32'd0);
        checkOutput("midrst_cmd_ready",   32'(cmd_ready),   32'd1);
        @(posedge CLK);
        #1;
        RST_N    = 1'b1;
        pos      = 0;
        expState = 0;
        Pulse    = 21'd3;
        measureFrame(hi);
        checkOutput("postrst_reset_width", 32'(hi), 32'd6);
        measureFrame(hi);
        checkOutput("postrst_new_width", 32'(hi), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
